// File: rtl/ps2_key_rx_fifo.sv
// ps2_key_rx_fifo
// Receives PS/2 keyboard frames, strips the E0/F0 prefix bytes into flags, and
// queues {ext, brk, code} key events in a show-ahead FIFO.
//
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   ps2_clk, ps2_data raw PS/2 lines (asynchronous to clk)
//   rd_en             pop request for the head event
//   ovf_clr           clears the sticky overflow flag
//   evt_valid         FIFO non-empty; evt_code/evt_ext/evt_brk show the head
//   fifo_count        number of stored events (0..2^FIFO_AW)
//   parity_err        one-cycle pulse on a frame with bad odd parity
//   frame_err         one-cycle pulse on a bad stop bit or an inter-edge timeout
//   overflow          sticky: an event was dropped because the FIFO was full
//   rx_state          receiver FSM state (0 IDLE, 1 DATA, 2 PARITY, 3 STOP)
//
// Handshake: evt_valid/rd_en form a valid/ready pair on the output side. An event
// transfers on a rising edge where evt_valid=1 and rd_en=1; rd_en while
// evt_valid=0 has no effect. The producer side has no backpressure: a write that
// finds the FIFO full (and no simultaneous pop) is dropped and sets overflow.
module ps2_key_rx_fifo #(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 5000,
  parameter int FIFO_AW     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             rd_en,
  input  logic             ovf_clr,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_brk,
  output logic [FIFO_AW:0] fifo_count,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overflow,
  output logic [1:0]       rx_state
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0]    FL      = 4'(FILT_LEN - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    B_EXT   = 8'hE0;
  localparam logic [7:0]    B_BRK   = 8'hF0;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

  // ---------------- synchronizer + glitch filter (bit 0 clock, bit 1 data)
  logic [1:0] raw, s1, s2, filt;
  logic [3:0] fcnt [2];
  logic       strobe;

  assign raw = {ps2_data, ps2_clk};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1      <= 2'b11;
      s2      <= 2'b11;
      filt    <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
      strobe  <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Strobe fires in the same edge that the filtered clock drops to 0.
      strobe <= filt[0] && !s2[0] && (fcnt[0] == FL);
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FL) begin
          filt[i] <= s2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 4'd1;
        end
      end
    end
  end

  // ---------------- frame receiver
  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          rx_done;
  logic [TW-1:0] to_cnt;

  assign rx_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      to_cnt     <= '0;
    end else begin
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (strobe) begin
        to_cnt <= '0;
        case (state)
          S_IDLE: begin
            if (!filt[1]) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            shreg   <= {filt[1], shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= filt[1];
            state   <= S_STOP;
          end
          default: begin
            state <= S_IDLE;
            if (!filt[1])                 frame_err  <= 1'b1;
            else if (!(^shreg ^ par_bit)) parity_err <= 1'b1;
            else                          rx_done    <= 1'b1;
          end
        endcase
      end else if (state != S_IDLE) begin
        if (to_cnt == TO_LAST) begin
          frame_err <= 1'b1;
          state     <= S_IDLE;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end
    end
  end

  // ---------------- prefix decoder
  // shreg still holds the received byte during the cycle rx_done is high.
  logic       ext_pend, brk_pend;
  logic       wr_req;
  logic [9:0] wr_data;

  assign wr_req  = rx_done && (shreg != B_EXT) && (shreg != B_BRK);
  assign wr_data = {ext_pend, brk_pend, shreg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (parity_err || frame_err) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (rx_done) begin
      if (shreg == B_EXT) begin
        ext_pend <= 1'b1;
      end else if (shreg == B_BRK) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  // ---------------- event FIFO (show-ahead)
  logic [9:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               full, do_pop, do_push;
  logic [9:0]         head;

  assign full      = (fifo_count == (FIFO_AW+1)'(DEPTH));
  assign evt_valid = (fifo_count != '0);
  assign do_pop    = rd_en && evt_valid;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign do_push   = wr_req && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      fifo_count <= fifo_count + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
      // A new overflow wins over a clear in the same cycle.
      if (wr_req && !do_push) overflow <= 1'b1;
      else if (ovf_clr)       overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Storage is not reset, so the head is masked to zero while the FIFO is empty.
  assign head     = evt_valid ? mem[rd_ptr] : 10'd0;
  assign evt_ext  = head[9];
  assign evt_brk  = head[8];
  assign evt_code = head[7:0];

endmodule

// File: tb/tb_ps2_key_rx_fifo.sv
module tb_ps2_key_rx_fifo;

  localparam int FILT_LEN    = 4;
  localparam int TIMEOUT_CYC = 1000;
  localparam int FIFO_AW     = 3;
  localparam int DEPTH       = 8;
  localparam int HALF_SLOW   = 200;
  localparam int HALF_FAST   = 40;

  logic clk = 1'b0, rst = 1'b0;
  logic ps2_clk = 1'b1, ps2_data = 1'b1, rd_en = 1'b0, ovf_clr = 1'b0;
  logic evt_valid, evt_ext, evt_brk, parity_err, frame_err, overflow;
  logic [7:0]       evt_code;
  logic [FIFO_AW:0] fifo_count;
  logic [1:0]       rx_state;

  logic [9:0] exp_q[$];
  logic m_ext = 1'b0, m_brk = 1'b0, exp_ovf = 1'b0;
  int checks = 0, errors = 0, cyc = 0;
  int par_seen = 0, frm_seen = 0, pulse_wide = 0;
  logic par_prev = 1'b0, frm_prev = 1'b0;

  ps2_key_rx_fifo #(
    .FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .FIFO_AW(FIFO_AW)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .ovf_clr(ovf_clr), .evt_valid(evt_valid),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_brk(evt_brk),
    .fifo_count(fifo_count), .parity_err(parity_err), .frame_err(frame_err),
    .overflow(overflow), .rx_state(rx_state)
  );

  // ---------------- clock / reset / monitors
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (parity_err) par_seen++;
    if (frame_err)  frm_seen++;
    if ((parity_err && par_prev) || (frame_err && frm_prev)) pulse_wide++;
    par_prev = parity_err;
    frm_prev = frame_err;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers
  task automatic send_bit(input logic b, input int half);
    ps2_data = b;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Sends one frame; optionally pops the head in the cycle the event is written.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit,
                            input logic pop_at_write, input int half);
    logic par;
    int k;
    logic [9:0] head_exp;
    logic is_evt, first;
    par = ~^b ^ bad_par;
    send_bit(1'b0, half);
    for (int i = 0; i < 8; i++) send_bit(b[i], half);
    send_bit(par, half);
    ps2_data = stop_bit;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b0;
    k = 0;
    while (rx_state != 2'd0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("stop_reaches_idle", 32'(k < 40), 32'd1);
    is_evt = stop_bit && !bad_par && (b != 8'hE0) && (b != 8'hF0);
    first  = is_evt && (exp_q.size() == 0) && !pop_at_write;
    if (pop_at_write) begin
      head_exp = (exp_q.size() > 0) ? exp_q[0] : 10'h3FF;
      check("pop_at_write_head", {evt_ext, evt_brk, evt_code}, head_exp);
      rd_en = 1'b1;
    end
    if (first) check("valid_before_write", evt_valid, 1'b0);
    @(negedge clk);
    rd_en = 1'b0;
    if (first) check("valid_2clk_after_strobe", evt_valid, 1'b1);
    if (pop_at_write && exp_q.size() > 0) void'(exp_q.pop_front());
    // reference decoder model
    if (!stop_bit || bad_par) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
      else exp_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    repeat (half) @(negedge clk);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  // Pops every event the DUT shows and compares against the expected queue.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (evt_valid && n < 20) begin
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected_event"}, evt_valid, 1'b0);
        break;
      end
      check(tag, {evt_ext, evt_brk, evt_code}, exp_q.pop_front());
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      n++;
    end
    check({tag, "_missing_events"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus
  initial begin
    int t0, delay, k;
    repeat (3) @(negedge clk);
    check("rst_evt_valid", evt_valid, 1'b0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_evt_head", {evt_ext, evt_brk, evt_code}, 10'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_errs", {parity_err, frame_err}, 2'b00);
    check("rst_state", rx_state, 2'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // single make code
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, HALF_SLOW);
    check("t1_count", fifo_count, 1);
    drain("t1_evt");

    // extended break sequence
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0, HALF_SLOW);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, HALF_SLOW);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0, HALF_SLOW);
    check("t2_count", fifo_count, 1);
    drain("t2_evt");

    // parity error drops byte and clears a pending E0
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0, HALF_SLOW);
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, HALF_SLOW);
    check("t3_parity_pulses", par_seen, 1);
    check("t3_no_event", fifo_count, 0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, HALF_SLOW);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, HALF_SLOW);
    drain("t3_evt");

    // stalled frame: start + 4 data bits then silence
    send_bit(1'b0, HALF_SLOW);
    send_bit(1'b1, HALF_SLOW);
    send_bit(1'b0, HALF_SLOW);
    send_bit(1'b1, HALF_SLOW);
    ps2_data = 1'b1;
    repeat (HALF_SLOW) @(negedge clk);
    ps2_clk = 1'b0;
    t0 = cyc;
    repeat (HALF_SLOW) @(negedge clk);
    ps2_clk = 1'b1;
    k = 0;
    while (!frame_err && k < TIMEOUT_CYC + 100) begin
      @(negedge clk);
      k++;
    end
    delay = cyc - t0;
    check("t4_timeout_seen", frame_err, 1'b1);
    check("t4_timeout_delay", 32'((delay >= TIMEOUT_CYC) && (delay <= TIMEOUT_CYC + 16)), 32'd1);
    @(negedge clk);
    check("t4_state_idle", rx_state, 2'd0);
    check("t4_frame_pulses", frm_seen, 1);
    m_ext = 1'b0;
    m_brk = 1'b0;
    send_frame(8'h1D, 1'b0, 1'b1, 1'b0, HALF_SLOW);
    drain("t4_evt");

    // bad stop bit drops byte and clears a pending E0
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0, HALF_FAST);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, HALF_FAST);
    check("t5_frame_pulses", frm_seen, 2);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, HALF_FAST);
    drain("t5_evt");

    // reset in the middle of a frame, with an E0 pending
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0, HALF_FAST);
    send_bit(1'b0, HALF_FAST);
    send_bit(1'b1, HALF_FAST);
    send_bit(1'b0, HALF_FAST);
    ps2_data = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_async_state", rx_state, 2'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_ext = 1'b0;
    m_brk = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h2A, 1'b0, 1'b1, 1'b0, HALF_FAST);
    drain("t6_evt");

    // overflow: nine make codes, no reads
    for (int i = 0; i < 9; i++) send_frame(8'(8'h10 + i), 1'b0, 1'b1, 1'b0, HALF_FAST);
    check("t7_count_full", fifo_count, DEPTH);
    check("t7_overflow", overflow, exp_ovf);
    check("t7_head_first", {evt_ext, evt_brk, evt_code}, exp_q[0]);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    check("t7_ovf_cleared", overflow, exp_ovf);

    // write into a full FIFO with a pop in the same cycle
    send_frame(8'h21, 1'b0, 1'b1, 1'b1, HALF_FAST);
    check("t8_count_full", fifo_count, DEPTH);
    check("t8_overflow", overflow, exp_ovf);
    drain("t8_evt");

    // pop on an empty FIFO is ignored
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("t9_empty_count", fifo_count, 0);
    check("t9_empty_valid", evt_valid, 1'b0);

    check("err_pulse_width", pulse_wide, 0);
    check("total_parity_pulses", par_seen, 1);
    check("total_frame_pulses", frm_seen, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_rx_fifo.md
PS2_KEY_RX_FIFO -- requirements
Module: ps2_key_rx_fifo

Interface
REQ-001 Parameter FILT_LEN, 4, number of consecutive equal samples before a filtered line changes level (2..16).
REQ-002 Parameter TIMEOUT_CYC, 5000, maximum clk cycles between PS/2 clock falling edges inside a frame.
REQ-003 Parameter FIFO_AW, 3, event FIFO address width; depth = 2^FIFO_AW.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-007 ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-008 rd_en  input  1  pop request for the head event.
REQ-009 ovf_clr  input  1  clears the sticky overflow flag.
REQ-010 evt_valid  output  1  FIFO non-empty; head event present on the evt_* outputs.
REQ-011 evt_code  output  8  head event scan code (make/break code byte, prefixes removed).
REQ-012 evt_ext  output  1  head event was preceded by an E0 prefix.
REQ-013 evt_brk  output  1  head event is a key release (preceded by F0).
REQ-014 fifo_count  output  FIFO_AW+1  number of stored events.
REQ-015 parity_err  output  1  one-cycle pulse on a frame with bad odd parity.
REQ-016 frame_err  output  1  one-cycle pulse on a bad stop bit or a timeout.
REQ-017 overflow  output  1  sticky; an event was dropped because the FIFO was full.

Function
REQ-018 Both PS/2 lines SHALL pass through a 2-flop synchronizer, then a filter that changes the filtered level only after FILT_LEN consecutive equal synchronized samples.
REQ-019 A falling edge SHALL be a one-cycle strobe when the filtered clock goes 1->0; filtered data SHALL be sampled on that strobe.
REQ-020 Frame format: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1.
REQ-021 Receiver FSM states: IDLE, DATA, PARITY, STOP. On a strobe, IDLE->DATA only if data=0, otherwise IDLE. DATA->PARITY after the 8th data bit. PARITY->STOP on the next strobe. STOP->IDLE on the next strobe.
REQ-022 In the STOP strobe: if data=0, pulse frame_err and discard the byte. Else, if XOR(data bits, parity bit) != 1, pulse parity_err and discard the byte. Else, deliver the byte to the decoder.
REQ-023 The timeout counter SHALL clear on each strobe and count while the FSM is not IDLE. When it reaches TIMEOUT_CYC: pulse frame_err, return to IDLE, discard partial data.
REQ-024 Decoder, byte E0: set the pending ext flag; no event.
REQ-025 Decoder, byte F0: set the pending brk flag; no event.
REQ-026 Decoder, any other byte: write {ext, brk, byte} to the FIFO, then clear both pending flags.
REQ-027 Any parity_err or frame_err SHALL clear both pending flags.
REQ-028 The FIFO write SHALL occur on the clk edge after the STOP strobe; evt_valid SHALL rise on the following edge for an empty FIFO (2 clk after the strobe).
REQ-029 The FIFO is show-ahead: the evt_* outputs always show the head. rd_en with evt_valid=1 pops on that edge. rd_en with evt_valid=0 is ignored.
REQ-030 Write when full with no pop: drop the event, set overflow; contents unchanged.
REQ-031 Write and pop in the same cycle (including when full): both execute; fifo_count unchanged.
REQ-032 Pointers SHALL wrap modulo 2^FIFO_AW; fifo_count is 0..2^FIFO_AW.
REQ-033 ovf_clr SHALL clear overflow. If ovf_clr and a new overflow occur in the same cycle, overflow stays 1.

Reset
REQ-034 rst=0 SHALL immediately force: FSM IDLE, counters and pointers 0, pending flags 0, filters to level 1, outputs evt_valid/fifo_count/parity_err/frame_err/overflow = 0.
REQ-035 evt_code, evt_ext and evt_brk SHALL read 0 after reset.
REQ-036 Reset mid-frame SHALL discard the partial frame; the next valid start bit after release SHALL be received normally.

Verification (FILT_LEN=4, PS/2 half-period 200 clk)
REQ-037 Frame 0x1C, parity 0 -> one event {ext=0, brk=0, code=1C}; evt_valid 2 clk after the stop strobe; fifo_count=1.
REQ-038 Frames E0, F0, 75 -> exactly one event {ext=1, brk=1, code=75}.
REQ-039 Frame 0x1C with parity 1 -> parity_err one-cycle pulse; no event; a following F0/1C yields brk=1, ext=0.
REQ-040 Frame stalled after 4 data bits -> frame_err TIMEOUT_CYC clk after the last strobe; FSM IDLE; the next frame 0x1D is received correctly.
REQ-041 FIFO_AW=3, 9 make codes with no reads -> fifo_count=8, overflow=1, head equals the first code; ovf_clr -> overflow=0.
REQ-042 Full FIFO, rd_en held during the 9th write -> fifo_count stays 8, overflow stays 0, order preserved.
